// File: rtl/button_debounce_counter_if.sv
// Board-side bundle for button_debounce_counter: raw buttons in, debounced state,
// edge pulses and the LED counter out.
interface button_debounce_counter_if #(
    parameter int NUM_BTN = 2,
    parameter int LED_W   = 6
);
    logic [NUM_BTN-1:0] button_n;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [LED_W-1:0]   count;
    logic [LED_W-1:0]   led;

    modport master (
        output button_n,
        input  btn_level, btn_press, btn_release, count, led
    );

    modport slave (
        input  button_n,
        output btn_level, btn_press, btn_release, count, led
    );
endinterface

// File: rtl/button_debounce_counter.sv
// Tick-sampled debouncer for NUM_BTN active-low buttons driving an up/down LED counter.
// Define AUTO_REPEAT_EN to add hold-to-repeat press pulses on buttons 0 and 1.
module button_debounce_counter #(
    parameter int NUM_BTN      = 2,
    parameter int TICK_DIV     = 270000,
    parameter int STABLE_TICKS = 3,
    parameter int LED_W        = 6,
    parameter int WRAP         = 1,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                      clk_27mhz,
    input  logic                      rst,
    button_debounce_counter_if.slave  bus
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int STB_W = $clog2(STABLE_TICKS + 1);

    if (NUM_BTN < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || LED_W < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("button_debounce_counter: illegal parameter setting");
    end

    logic [NUM_BTN-1:0] sync1, sync2;
    logic [NUM_BTN-1:0] level, level_d, press, rel_q;
    logic [NUM_BTN-1:0] accept, rpt;
    logic [DIV_W-1:0]   div;
    logic               tick;
    logic [LED_W-1:0]   cnt, cnt_nxt, led_q;
    logic               up, down;

    assign tick = (div == DIV_W'(TICK_DIV - 1));

    // Inversion sits at the first stage so both stages reset to "released".
    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            div   <= '0;
        end else begin
            sync1 <= ~bus.button_n;
            sync2 <= sync1;
            div   <= tick ? '0 : div + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [STB_W-1:0] stab;

        assign accept[i] = tick && (sync2[i] != level[i]) &&
                           (stab == STB_W'(STABLE_TICKS - 1));

        always_ff @(posedge clk_27mhz) begin
            if (rst) begin
                stab <= '0;
            end else if (tick) begin
                if (sync2[i] == level[i] || accept[i]) stab <= '0;
                else                                   stab <= stab + 1'b1;
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int NUM_RPT = (NUM_BTN < 2) ? NUM_BTN : 2;

    logic [NUM_RPT-1:0] rpt_hit;

    for (genvar i = 0; i < NUM_RPT; i++) begin : g_rpt
        logic [RPT_W-1:0] hold, target;
        logic             repeating, hold_on;

        // A tick that accepts the release must not also fire a repeat.
        assign hold_on    = level[i] & ~accept[i];
        assign target     = repeating ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);
        assign rpt_hit[i] = tick && hold_on && (hold + 1'b1 == target);

        always_ff @(posedge clk_27mhz) begin
            if (rst || !hold_on) begin
                hold      <= '0;
                repeating <= 1'b0;
            end else if (tick) begin
                if (rpt_hit[i]) begin
                    hold      <= '0;
                    repeating <= 1'b1;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst) rpt <= '0;
        else     rpt <= NUM_BTN'(rpt_hit);
    end
`else
    assign rpt = '0;
`endif

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            level   <= '0;
            level_d <= '0;
            press   <= '0;
            rel_q   <= '0;
        end else begin
            level   <= level ^ accept;
            level_d <= level;
            press   <= (level & ~level_d) | rpt;
            rel_q   <= ~level & level_d;
        end
    end

    assign up = press[0];
    if (NUM_BTN >= 2) begin : g_down
        assign down = press[1];
    end else begin : g_no_down
        assign down = 1'b0;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (up && !down) begin
            if (WRAP != 0 || cnt != '1) cnt_nxt = cnt + 1'b1;
        end else if (down && !up) begin
            if (WRAP != 0 || cnt != '0) cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            cnt   <= '0;
            led_q <= '1;
        end else begin
            cnt   <= cnt_nxt;
            led_q <= ~cnt_nxt;
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel_q;
    assign bus.count       = cnt;
    assign bus.led         = led_q;
endmodule
